// File: rtl/timer_seq_pkg.sv
// Shared constants for the interval-timer sequencing master: command opcodes,
// FSM state codes, timer register map and control register bit positions.
package timer_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned ST_W   = 4;

    localparam logic [1:0] OP_START_ONESHOT = 2'd0;
    localparam logic [1:0] OP_START_CONT    = 2'd1;
    localparam logic [1:0] OP_STOP          = 2'd2;
    localparam logic [1:0] OP_SNAPSHOT      = 2'd3;

    localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [ST_W-1:0] ST_WR_PL   = 4'd1;
    localparam logic [ST_W-1:0] ST_WR_PH   = 4'd2;
    localparam logic [ST_W-1:0] ST_WR_CTRL = 4'd3;
    localparam logic [ST_W-1:0] ST_SNAP_W  = 4'd4;
    localparam logic [ST_W-1:0] ST_RD_L    = 4'd5;
    localparam logic [ST_W-1:0] ST_RD_H    = 4'd6;
    localparam logic [ST_W-1:0] ST_RD_DONE = 4'd7;
    localparam logic [ST_W-1:0] ST_CLR_ST  = 4'd8;

    localparam logic [ADDR_W-1:0] REG_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] REG_CONTROL = 3'd1;
    localparam logic [ADDR_W-1:0] REG_PERIODL = 3'd2;
    localparam logic [ADDR_W-1:0] REG_PERIODH = 3'd3;
    localparam logic [ADDR_W-1:0] REG_SNAPL   = 3'd4;
    localparam logic [ADDR_W-1:0] REG_SNAPH   = 3'd5;

    localparam int unsigned CTRL_ITO_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_STOP_BIT  = 3;

    // Control register image for a given command; ITO is carried on every write.
    function automatic logic [DATA_W-1:0] ctrl_word(input logic [1:0] op, input logic ito);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_ITO_BIT] = ito;
        case (op)
            OP_START_CONT: begin
                w[CTRL_START_BIT] = 1'b1;
                w[CTRL_CONT_BIT]  = 1'b1;
            end
            OP_START_ONESHOT: w[CTRL_START_BIT] = 1'b1;
            OP_STOP:          w[CTRL_STOP_BIT]  = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/timer_seq_master.sv
// Avalon-MM master that expands single-beat timer commands into register sequences
// and services the timer irq. Optional tick counter: TIMER_SEQ_TICK_CNT_EN.
module timer_seq_master
    import timer_seq_pkg::*;
#(
    parameter logic        CTRL_ITO = 1'b1,
    parameter int unsigned TICK_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              timer_irq
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       period_q, period_d;
    logic [31:0]       snap_d;
    logic              snap_valid_d;
    logic              tick_d;
    logic [ADDR_W-1:0] addr_d;
    logic              cs_d;
    logic              write_n_d;
    logic [DATA_W-1:0] wdata_d;

    // The irq wins over a new command; nothing is accepted while in reset.
    assign cmd_ready = (state_q == ST_IDLE) && !timer_irq && !reset;

    // Next state, then the bus cycle of the state being entered, so the bus
    // registers present each state's cycle for exactly the clock it occupies.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        period_d     = period_q;
        snap_d       = snap_value;
        snap_valid_d = 1'b0;
        tick_d       = 1'b0;
        addr_d       = '0;
        cs_d         = 1'b0;
        write_n_d    = 1'b1;
        wdata_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (timer_irq) begin
                    state_d = ST_CLR_ST;
                end else if (cmd_valid) begin
                    op_d     = cmd_op;
                    period_d = cmd_period;
                    case (cmd_op)
                        OP_START_ONESHOT, OP_START_CONT: state_d = ST_WR_PL;
                        OP_STOP:                         state_d = ST_WR_CTRL;
                        default:                         state_d = ST_SNAP_W;
                    endcase
                end
            end
            ST_WR_PL:   state_d = ST_WR_PH;
            ST_WR_PH:   state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = ST_IDLE;
            ST_SNAP_W:  state_d = ST_RD_L;
            ST_RD_L:    state_d = ST_RD_H;
            ST_RD_H: begin
                snap_d[15:0] = avm_readdata;
                state_d      = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                snap_d[31:16] = avm_readdata;
                snap_valid_d  = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_CLR_ST:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_WR_PL: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = REG_PERIODL;
                wdata_d   = period_d[15:0];
            end
            ST_WR_PH: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = REG_PERIODH;
                wdata_d   = period_d[31:16];
            end
            ST_WR_CTRL: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = REG_CONTROL;
                wdata_d   = ctrl_word(op_d, CTRL_ITO);
            end
            ST_SNAP_W: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = REG_SNAPL;
            end
            ST_RD_L: begin
                cs_d   = 1'b1;
                addr_d = REG_SNAPL;
            end
            ST_RD_H: begin
                cs_d   = 1'b1;
                addr_d = REG_SNAPH;
            end
            ST_CLR_ST: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = REG_STATUS;
                tick_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_START_ONESHOT;
            period_q       <= '0;
            snap_value     <= '0;
            snap_valid     <= 1'b0;
            tick           <= 1'b0;
            busy           <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            period_q       <= period_d;
            snap_value     <= snap_d;
            snap_valid     <= snap_valid_d;
            tick           <= tick_d;
            busy           <= (state_d != ST_IDLE);
            avm_address    <= addr_d;
            avm_chipselect <= cs_d;
            avm_write_n    <= write_n_d;
            avm_writedata  <= wdata_d;
        end
    end

`ifdef TIMER_SEQ_TICK_CNT_EN
    logic [TICK_W-1:0] tick_count_q;

    // Saturating count of serviced timeouts, stepped with the tick pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count_q <= '0;
        end else if (tick_d && (tick_count_q != {TICK_W{1'b1}})) begin
            tick_count_q <= tick_count_q + TICK_W'(1);
        end
    end

    assign tick_count = tick_count_q;
`else
    assign tick_count = '0;
`endif

endmodule
